// File: rtl/ipsxb_cmd_arb_32bit_pkg.sv
// ipsxb_cmd_arb_32bit_pkg: shared widths, error pattern and FSM encoding for the command arbiter
package ipsxb_cmd_arb_32bit_pkg;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/ipsxb_cmd_arb_32bit_if.sv
// ipsxb_cmd_arb_32bit_if: requester and downstream register-bus signals of the command arbiter
interface ipsxb_cmd_arb_32bit_if;
   import ipsxb_cmd_arb_32bit_pkg::*;
   logic              req0, req1, we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1, done0, done1, err0, err1;
   logic [DATA_W-1:0] rdata0, rdata1;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic              we, cmd_en, cmd_done, busy;
   logic [DATA_W-1:0] dn_rdata;
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, cmd_done, dn_rdata,
      output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1, addr, data, we, cmd_en, busy
   );
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, cmd_done, dn_rdata,
      input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1, addr, data, we, cmd_en, busy
   );
endinterface

// File: rtl/ipsxb_rr_arb2.sv
// ipsxb_rr_arb2: combinational 2-way round-robin picker, one-hot select
module ipsxb_rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] sel
);
   // on contention the requester not served last wins
   assign sel = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};
endmodule

// File: rtl/ipsxb_cmd_arb_32bit.sv
// ipsxb_cmd_arb_32bit: two-requester arbiter/sequencer for the UART control register block
module ipsxb_cmd_arb_32bit
   import ipsxb_cmd_arb_32bit_pkg::*;
#(
   parameter int               TIMEOUT_CYC = 1024,
   parameter logic [DATA_W-1:0] ERR_DATA   = ERR_DATA_DEF
) (
   input logic                    clk,
   input logic                    rst_n,
   ipsxb_cmd_arb_32bit_if.slave   bus
);
   localparam int CW = $clog2(TIMEOUT_CYC);
   state_t            state, state_nx;
   logic [1:0]        pick, sel;
   logic              last, err_q, expire;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] rdata_q;
   ipsxb_rr_arb2 u_rr (.req({bus.req1, bus.req0}), .last(last), .sel(pick));
   assign expire = cnt == CW'(TIMEOUT_CYC - 1);
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE && |pick) ? ISSUE :
                 state == ISSUE ? WAIT :
                 (state == WAIT && (bus.cmd_done || expire)) ? RESP :
                 state == RESP ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sel     <= '0;
         last    <= 1'b1;
         cnt     <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         bus.addr <= '0;
         bus.data <= '0;
         bus.we   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && |pick) begin
            sel      <= pick;
            bus.addr <= pick[1] ? bus.addr1 : bus.addr0;
            bus.data <= pick[1] ? bus.wdata1 : bus.wdata0;
            bus.we   <= pick[1] ? bus.we1 : bus.we0;
         end
         cnt <= state == ISSUE ? '0 : (state == WAIT && !(&cnt)) ? cnt + 1'b1 : cnt;
         if (state == WAIT) begin
            rdata_q <= bus.we ? '0 : bus.cmd_done ? bus.dn_rdata : ERR_DATA;
            err_q   <= !bus.cmd_done;
         end
         if (state == RESP) last <= sel[1];
      end
   end
   assign bus.cmd_en = state == ISSUE;
   assign bus.gnt0   = state == ISSUE && sel[0];
   assign bus.gnt1   = state == ISSUE && sel[1];
   assign bus.done0  = state == RESP && sel[0];
   assign bus.done1  = state == RESP && sel[1];
   assign bus.err0   = bus.done0 && err_q;
   assign bus.err1   = bus.done1 && err_q;
   assign bus.rdata0 = bus.done0 ? rdata_q : '0;
   assign bus.rdata1 = bus.done1 ? rdata_q : '0;
   assign bus.busy   = state != IDLE;
endmodule

// File: tb/tb_ipsxb_cmd_arb_32bit.sv
// tb_ipsxb_cmd_arb_32bit: directed self-checking bench for the command arbiter (TIMEOUT_CYC=16)
module tb_ipsxb_cmd_arb_32bit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0, bad = 0;
   int   n_en = 0, n_gnt = 0, n_both = 0;
   ipsxb_cmd_arb_32bit_if bus ();
   ipsxb_cmd_arb_32bit #(.TIMEOUT_CYC(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      if (bus.cmd_en) n_en++;
      if (bus.gnt0 | bus.gnt1) n_gnt++;
      if ((bus.gnt0 & bus.gnt1) | (bus.done0 & bus.done1)) n_both++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(negedge clk);
   endtask
   function automatic logic [31:0] outs;
      return bus.data | bus.rdata0 | bus.rdata1 |
             {bus.addr, bus.busy, bus.cmd_en, bus.we, bus.gnt0, bus.gnt1,
              bus.done0, bus.done1, bus.err0, bus.err1, 14'd0};
   endfunction
   task automatic wait_gnt(output int who);
      who = -1;
      for (int i = 0; i < 10 && who < 0; i++) begin
         tick();
         if (bus.gnt0) who = 0;
         else if (bus.gnt1) who = 1;
      end
      if (who < 0) chk("gnt_wait", 0, 1);
   endtask
   task automatic raise(input int r, input logic w, input logic [8:0] a, input logic [31:0] wd);
      if (r == 0) begin bus.req0 = 1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = wd; end
      else begin bus.req1 = 1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = wd; end
   endtask
   // lat: cycle after cmd_en carrying cmd_done (0 = never); done_at: cycle after cmd_en expecting done
   task automatic xact(input string tag, input int r, input logic w, input logic [8:0] a,
                       input logic [31:0] wd, input int lat, input logic [31:0] dr,
                       input int done_at, input logic [31:0] exp_rd, input logic exp_err);
      int who;
      logic early = 0, other = 0, moved = 0;
      raise(r, w, a, wd);
      tick();
      who = (bus.gnt0 & bus.cmd_en) ? 0 : (bus.gnt1 & bus.cmd_en) ? 1 : -1;
      chk({tag, "_gnt"}, who, r);
      chk({tag, "_issue"}, {bus.addr, bus.we, 22'd0} ^ bus.data, {a, w, 22'd0} ^ wd);
      bus.req0 = 0;
      bus.req1 = 0;
      for (int k = 1; k <= done_at; k++) begin
         tick();
         bus.cmd_done = 0;
         if ((r == 0 ? bus.gnt1 | bus.done1 : bus.gnt0 | bus.done0)) other = 1;
         if (k < done_at) begin
            if (bus.done0 | bus.done1) early = 1;
            if (bus.addr !== a || bus.data !== wd || bus.we !== w) moved = 1;
         end
         if (k == lat) begin bus.cmd_done = 1; bus.dn_rdata = dr; end
      end
      chk({tag, "_done"}, r == 0 ? bus.done0 : bus.done1, 1);
      chk({tag, "_rdata"}, r == 0 ? bus.rdata0 : bus.rdata1, exp_rd);
      chk({tag, "_err"}, r == 0 ? bus.err0 : bus.err1, exp_err);
      chk({tag, "_quiet"}, {early, other, moved}, 0);
      tick();
      chk({tag, "_idle"}, {bus.busy, bus.done0, bus.done1}, 0);
   endtask
   initial begin
      int who, base;
      bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
      bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
      bus.cmd_done = 0; bus.dn_rdata = 0;
      repeat (2) tick();
      chk("reset_outs", outs(), 0);
      rst_n = 1;
      tick();
      xact("t1", 0, 1, 9'h003, 32'h1234_5678, 4, 32'hFFFF_FFFF, 5, 32'h0, 0);
      xact("t2", 1, 0, 9'h0FF, 32'h0, 2, 32'h2020_0729, 3, 32'h2020_0729, 0);
      rst_n = 0;
      tick();
      rst_n = 1;
      base = n_en;
      bus.we0 = 0; bus.we1 = 0; bus.addr0 = 9'h010; bus.addr1 = 9'h011;
      bus.req0 = 1; bus.req1 = 1;
      for (int g = 0; g < 4; g++) begin
         wait_gnt(who);
         chk("t3_order", who, g % 2);
         if (who == 0) bus.req0 = 0; else bus.req1 = 0;
         tick();
         bus.cmd_done = 1;
         bus.dn_rdata = 32'h100 + g;
         tick();
         bus.cmd_done = 0;
         chk("t3_done", who == 0 ? {bus.done0, bus.rdata0} : {bus.done1, bus.rdata1}, {1'b1, 32'h100 + g});
         if (g < 2) begin if (who == 0) bus.req0 = 1; else bus.req1 = 1; end
      end
      tick();
      chk("t3_en_count", n_en - base, 4);
      xact("t4", 0, 0, 9'h005, 32'h0, 0, 32'h0, 17, 32'hDEAD_BEEF, 1);
      xact("t5", 1, 0, 9'h006, 32'h0, 16, 32'hA5A5_0001, 17, 32'hA5A5_0001, 0);
      raise(0, 0, 9'h007, 32'h0);
      wait_gnt(who);
      chk("t6_gnt", who, 0);
      bus.req0 = 0;
      repeat (2) tick();
      rst_n = 0;
      tick();
      chk("t6_rst_outs", outs(), 0);
      tick();
      rst_n = 1;
      bus.cmd_done = 1;
      bus.dn_rdata = 32'h5555_5555;
      tick();
      bus.cmd_done = 0;
      chk("t6_stray", {bus.busy, bus.done0, bus.done1}, 0);
      tick();
      chk("t6_stray2", {bus.busy, bus.done0, bus.done1}, 0);
      raise(1, 1, 9'h009, 32'h1);
      raise(0, 1, 9'h008, 32'h2);
      wait_gnt(who);
      chk("t6_favour0", who, 0);
      chk("t6_addr", bus.addr, 9'h008);
      bus.req0 = 0; bus.req1 = 0;
      tick();
      bus.cmd_done = 1;
      tick();
      bus.cmd_done = 0;
      chk("t6_done", {bus.done0, bus.err0, bus.rdata0}, {1'b1, 1'b0, 32'h0});
      tick();
      chk("excl", n_both, 0);
      chk("gnt_eq_en", n_gnt, n_en);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
